fp32_mul_normalize: RTL and testbench

- Post-multiply stage of the FP32 multiplier datapath.
- Consumes the 48-bit mantissa product from multiplier_24bit, plus sign, exponent sum and special-case flags that arrive time-aligned with it.
- Normalizes the product, rounds to nearest-even, and applies overflow/underflow/special handling.
- Emits a packed IEEE-754 single under a valid/ready handshake. Two-stage pipeline with whole-pipe stall.

---
 rtl/fp32_pkg.sv | 22 ++
 rtl/fp32_mul_normalize_if.sv | 28 ++
 rtl/fp_round_rne.sv | 30 +++
 rtl/fp32_mul_normalize.sv | 130 +++++++++++++
 tb/tb_fp32_mul_normalize.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared constants and stage-1 register layout for the FP32 multiply post-stage
package fp32_pkg;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] MAXF    = 31'h7F7F_FFFF;

  // Normalized product waiting for rounding; exponent is 11-bit signed so
  // the +1 from normalization and rounding can never wrap.
  typedef struct packed {
    logic               sign;
    logic signed [10:0] exp;
    logic [22:0]        mant;
    logic               g;
    logic               s;
    logic               zero;
    logic               inf;
    logic               nan;
  } norm_s;

endpackage

// File: rtl/fp32_mul_normalize_if.sv
// rtl/fp32_mul_normalize_if.sv - valid/ready input and output streams of the post-multiply stage
interface fp32_mul_normalize_if;

  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_prod;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_udf;

  modport master (
    output in_valid, in_prod, in_sign, in_exp, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_udf
  );

  modport slave (
    input  in_valid, in_prod, in_sign, in_exp, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_udf
  );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even of a 23-bit fraction with exponent bump on carry
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic [22:0]        mant,
  input  logic               g,
  input  logic               s,
  input  logic signed [10:0] exp,
  output logic [22:0]        mant_r,
  output logic signed [10:0] exp_r
);

  logic        up;
  logic [23:0] sum;

  // Round up on guard set unless it is an exact tie on an even LSB; an
  // all-ones fraction rolling over becomes 1.0 at the next exponent.
  always_comb begin
    up  = g & (s | mant[0]);
    sum = {1'b0, mant} + {23'd0, up};
    if (sum[23]) begin
      mant_r = '0;
      exp_r  = exp + 11'sd1;
    end else begin
      mant_r = sum[22:0];
      exp_r  = exp;
    end
  end

endmodule

// File: rtl/fp32_mul_normalize.sv
// rtl/fp32_mul_normalize.sv - two-stage normalize/round/pack of an FP32 mantissa product
module fp32_mul_normalize
  import fp32_pkg::*;
#(
  parameter bit SAT_ON_OVF = 1'b0
) (
  input logic                 clk,
  input logic                 rstn,
  fp32_mul_normalize_if.slave bus
);

  logic               advance;
  norm_s              norm_d;
  norm_s              s1_d, s1_q;
  logic               s1_valid_d, s1_valid_q;
  logic [22:0]        mant_r;
  logic signed [10:0] exp_r;
  logic [31:0]        res_data;
  logic               res_ovf, res_udf;
  logic               out_valid_d, out_valid_q;
  logic [31:0]        out_data_d, out_data_q;
  logic               out_ovf_d, out_ovf_q;
  logic               out_udf_d, out_udf_q;

  // Whole pipe moves together; it only freezes when a result is held unconsumed.
  assign advance = ~out_valid_q | bus.out_ready;

  // Stage 1: pick the leading one position and split fraction/guard/sticky.
  always_comb begin
    norm_d      = '0;
    norm_d.sign = bus.in_sign;
    norm_d.zero = bus.in_zero;
    norm_d.inf  = bus.in_inf;
    norm_d.nan  = bus.in_nan;
    if (bus.in_prod[47]) begin
      norm_d.mant = bus.in_prod[46:24];
      norm_d.g    = bus.in_prod[23];
      norm_d.s    = |bus.in_prod[22:0];
      norm_d.exp  = $signed({bus.in_exp[9], bus.in_exp}) + 11'sd1;
    end else begin
      norm_d.mant = bus.in_prod[45:23];
      norm_d.g    = bus.in_prod[22];
      norm_d.s    = |bus.in_prod[21:0];
      norm_d.exp  = $signed({bus.in_exp[9], bus.in_exp});
    end
  end

  // Stage-1 register next state: load on advance, otherwise hold.
  always_comb begin
    s1_d       = advance ? norm_d : s1_q;
    s1_valid_d = advance ? bus.in_valid : s1_valid_q;
  end

  fp_round_rne u_round (
    .mant   (s1_q.mant),
    .g      (s1_q.g),
    .s      (s1_q.s),
    .exp    (s1_q.exp),
    .mant_r (mant_r),
    .exp_r  (exp_r)
  );

  // Stage 2: special operands first, then range checks on the rounded exponent.
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    res_udf  = 1'b0;
    if (s1_q.nan) begin
      res_data = QNAN;
    end else if (s1_q.inf) begin
      res_data = {s1_q.sign, EXP_INF, 23'h0};
    end else if (s1_q.zero) begin
      res_data = {s1_q.sign, 31'h0};
    end else if (exp_r >= 11'sd255) begin
      res_ovf  = 1'b1;
      if (SAT_ON_OVF) begin
        res_data = {s1_q.sign, MAXF};
      end else begin
        res_data = {s1_q.sign, EXP_INF, 23'h0};
      end
    end else if (exp_r <= 11'sd0) begin
      res_data = {s1_q.sign, 31'h0};
      res_udf  = 1'b1;
    end else begin
      res_data = {s1_q.sign, exp_r[7:0], mant_r};
    end
  end

  // Output register next state: capture a valid stage-1 beat on advance.
  always_comb begin
    out_valid_d = advance ? s1_valid_q : out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_udf_d   = out_udf_q;
    if (advance && s1_valid_q) begin
      out_data_d = res_data;
      out_ovf_d  = res_ovf;
      out_udf_d  = res_udf;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_udf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_udf_q   <= out_udf_d;
    end
  end

  // Stage-1 data register; its contents are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_udf   = out_udf_q;

endmodule

// File: tb/tb_fp32_mul_normalize.sv
// tb/tb_fp32_mul_normalize.sv - directed-vector bench for fp32_mul_normalize
module tb_fp32_mul_normalize;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  fp32_mul_normalize_if bus0 ();
  fp32_mul_normalize_if bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_prod   = bus0.in_prod;
  assign bus1.in_sign   = bus0.in_sign;
  assign bus1.in_exp    = bus0.in_exp;
  assign bus1.in_zero   = bus0.in_zero;
  assign bus1.in_inf    = bus0.in_inf;
  assign bus1.in_nan    = bus0.in_nan;
  assign bus1.out_ready = bus0.out_ready;

  fp32_mul_normalize #(.SAT_ON_OVF(1'b0)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  fp32_mul_normalize #(.SAT_ON_OVF(1'b1)) u_dut_sat (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [47:0] prod, input logic [9:0] e,
                       input logic sg, input logic z, input logic inf, input logic nan);
    bus0.in_valid = v;
    bus0.in_prod  = prod;
    bus0.in_exp   = e;
    bus0.in_sign  = sg;
    bus0.in_zero  = z;
    bus0.in_inf   = inf;
    bus0.in_nan   = nan;
  endtask

  // Called at posedge+1; presents one beat and checks its result two cycles on.
  task automatic send_one(input string tag, input logic [47:0] prod, input logic [9:0] e,
                          input logic sg, input logic z, input logic inf, input logic nan,
                          input logic [31:0] exp_data, input logic exp_ovf, input logic exp_udf,
                          input logic [31:0] exp_sat);
    bus0.out_ready = 1'b1;
    drive(1'b1, prod, e, sg, z, inf, nan);
    #3;
    check({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 48'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_early"}, 64'(bus0.out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(bus0.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus0.out_data), 64'(exp_data));
    check({tag, "_ovf"}, 64'(bus0.out_ovf), 64'(exp_ovf));
    check({tag, "_udf"}, 64'(bus0.out_udf), 64'(exp_udf));
    check({tag, "_sat_data"}, 64'(bus1.out_data), 64'(exp_sat));
    @(posedge clk); #1;
  endtask

  logic [47:0] sp [4];
  logic [31:0] se [4];
  int          idx;
  int          got;
  int          stale;
  logic        acc;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    bus0.out_ready = 1'b1;
    drive(1'b0, 48'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_out_data", 64'(bus0.out_data), 64'd0);
    check("rst_out_ovf", 64'(bus0.out_ovf), 64'd0);
    check("rst_out_udf", 64'(bus0.out_udf), 64'd0);
    check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    rstn = 1'b1;
    @(posedge clk); #1;

    send_one("mul_1p5", 48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h4010_0000, 1'b0, 1'b0, 32'h4010_0000);
    send_one("tie_even", 48'h4000_0040_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000);
    send_one("tie_odd", 48'h4000_00C0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h3F80_0002, 1'b0, 1'b0, 32'h3F80_0002);
    send_one("rnd_carry", 48'h7FFF_FFC0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h4000_0000, 1'b0, 1'b0, 32'h4000_0000);
    send_one("ovf", 48'h8000_0000_0000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h7F80_0000, 1'b1, 1'b0, 32'h7F7F_FFFF);
    send_one("ovf_neg", 48'h8000_0000_0000, 10'd254, 1'b1, 1'b0, 1'b0, 1'b0,
             32'hFF80_0000, 1'b1, 1'b0, 32'hFF7F_FFFF);
    send_one("max_exp", 48'h4000_0000_0000, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h7F00_0000, 1'b0, 1'b0, 32'h7F00_0000);
    send_one("udf", 48'h4000_0000_0000, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000);
    send_one("min_exp", 48'h4000_0000_0000, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0080_0000, 1'b0, 1'b0, 32'h0080_0000);
    send_one("udf_negexp", 48'h8000_0000_0000, 10'h3F6, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000);
    send_one("nan", 48'h9000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b0, 1'b1,
             32'h7FC0_0000, 1'b0, 1'b0, 32'h7FC0_0000);
    send_one("inf_neg", 48'h9000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b1, 1'b0,
             32'hFF80_0000, 1'b0, 1'b0, 32'hFF80_0000);
    send_one("zero_neg", 48'h0000_0000_0000, 10'd127, 1'b1, 1'b1, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000);
    send_one("zero_inf_nan", 48'h0000_0000_0000, 10'd127, 1'b0, 1'b1, 1'b1, 1'b1,
             32'h7FC0_0000, 1'b0, 1'b0, 32'h7FC0_0000);

    // Back-to-back stream with a three-cycle consumer stall.
    sp[0] = 48'h9000_0000_0000; se[0] = 32'h4010_0000;
    sp[1] = 48'h4000_0040_0000; se[1] = 32'h3F80_0000;
    sp[2] = 48'h4000_00C0_0000; se[2] = 32'h3F80_0002;
    sp[3] = 48'h7FFF_FFC0_0000; se[3] = 32'h4000_0000;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      drive(idx < 4, sp[idx < 4 ? idx : 0], 10'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      bus0.out_ready = !(cyc >= 2 && cyc < 5);
      #3;
      if (cyc >= 2 && cyc < 5) begin
        check($sformatf("stall%0d_in_ready", cyc), 64'(bus0.in_ready), 64'd0);
        check($sformatf("stall%0d_out_valid", cyc), 64'(bus0.out_valid), 64'd1);
        check($sformatf("stall%0d_out_data", cyc), 64'(bus0.out_data), 64'(se[0]));
      end
      acc = bus0.in_valid && bus0.in_ready;
      if (bus0.out_valid && bus0.out_ready) begin
        if (got < 4) check($sformatf("stream_out%0d", got), 64'(bus0.out_data), 64'(se[got]));
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("stream_count", 64'(got), 64'd4);
    drive(1'b0, 48'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset with one beat in the output register and one in stage 1.
    drive(1'b1, 48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 48'h8000_0000_0000, 10'd127, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 48'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus0.out_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus0.in_ready), 64'd1);
    rstn = 1'b1;
    bus0.out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      #3;
      if (bus0.out_valid) stale++;
      @(posedge clk); #1;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
